// File: rtl/mac_requant_sign_if.sv
// mac_requant_sign_if: operand input and result output handshake bundle
interface mac_requant_sign_if #(parameter int WIDTH = 8);
  logic inValid;
  logic inReady;
  logic signed [WIDTH-1:0] dataA;
  logic signed [WIDTH-1:0] dataB;
  logic signed [WIDTH-1:0] dataOut;
  logic outValid;
  logic outReady;
  modport master (output inValid, dataA, dataB, outReady, input inReady, dataOut, outValid);
  modport slave (input inValid, dataA, dataB, outReady, output inReady, dataOut, outValid);
endinterface

// File: rtl/mac_requant_sign.sv
// mac_requant_sign: signed MAC over LEN pairs, then round, shift and saturate back to WIDTH bits
module mac_requant_sign #(
  parameter int WIDTH = 8,
  parameter int DECIMAL_POINT = 6,
  parameter int LEN = 16,
  parameter int ACC_WIDTH = 24
) (
  input logic iClk,
  input logic iRst,
  mac_requant_sign_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(-(1 <<< (WIDTH - 1)));
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1 <<< (DECIMAL_POINT - 1));
  typedef enum logic [1:0] {ACCUM, REQUANT, OUT} state_t;
  state_t state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, r;
  logic signed [2*WIDTH-1:0] prod;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] sat;
  logic accept;
  assign prod = bus.dataA * bus.dataB;
  assign accept = state == ACCUM && bus.inValid;
  assign bus.inReady = state == ACCUM;
  assign bus.outValid = state == OUT;
  // rounding adds half an LSB before the arithmetic shift: ties go toward +inf
  always_comb begin
    r = (acc + HALF) >>> DECIMAL_POINT;
    sat = r > MAXV ? MAXV[WIDTH-1:0] : r < MINV ? MINV[WIDTH-1:0] : r[WIDTH-1:0];
  end
  always_comb begin
    state_n = state == ACCUM ? (accept && count == CW'(LEN - 1) ? REQUANT : ACCUM)
            : state == REQUANT ? OUT
            : (bus.outReady ? ACCUM : OUT);
  end
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state <= ACCUM;
      acc <= '0;
      count <= '0;
      bus.dataOut <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc <= acc + ACC_WIDTH'(prod);
        count <= count + 1'b1;
      end
      if (state == REQUANT) bus.dataOut <= sat;
      if (state == OUT && bus.outReady) begin
        acc <= '0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mac_requant_sign.sv
// tb_mac_requant_sign: directed vector table plus handshake/reset sequences for mac_requant_sign
module tb_mac_requant_sign;
  logic iClk = 0;
  logic iRst;
  int tests = 0;
  int fails = 0;
  mac_requant_sign_if #(.WIDTH(8)) bus();
  mac_requant_sign #(.WIDTH(8), .DECIMAL_POINT(6), .LEN(4), .ACC_WIDTH(24)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus(bus)
  );
  always #5 iClk = ~iClk;
  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t v[10];
  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3, e);
    vec_t t;
    t.a[0] = 8'(a0); t.a[1] = 8'(a1); t.a[2] = 8'(a2); t.a[3] = 8'(a3);
    t.b[0] = 8'(b0); t.b[1] = 8'(b1); t.b[2] = 8'(b2); t.b[3] = 8'(b3);
    t.exp = 8'(e);
    return t;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // drive one pair at a negedge; returns at the negedge after it was accepted
  task automatic send(input int a, input int b);
    logic rdy;
    bus.inValid = 1;
    bus.dataA = 8'(a);
    bus.dataB = 8'(b);
    for (int i = 0; i < 20; i++) begin
      rdy = bus.inReady;
      @(negedge iClk);
      if (rdy) begin
        bus.inValid = 0;
        return;
      end
    end
    bus.inValid = 0;
    chk("send_timeout", 0, 1);
  endtask
  task automatic get_out(output int d);
    for (int i = 0; i < 20; i++) begin
      if (bus.outValid) begin
        d = int'($signed(bus.dataOut));
        @(negedge iClk);
        return;
      end
      @(negedge iClk);
    end
    d = -999;
    chk("out_timeout", 0, 1);
  endtask
  task automatic group(input vec_t t, output int d);
    for (int k = 0; k < 4; k++) send(int'($signed(t.a[k])), int'($signed(t.b[k])));
    get_out(d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, n;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    v[0] = mk(32, 32, 32, 32, 32, 32, 32, 32, 64);
    v[1] = mk(1, 0, 0, 0, 32, 0, 0, 0, 1);
    v[2] = mk(1, 0, 0, 0, 31, 0, 0, 0, 0);
    v[3] = mk(-1, 0, 0, 0, 32, 0, 0, 0, 0);
    v[4] = mk(-1, 0, 0, 0, 33, 0, 0, 0, -1);
    v[5] = mk(64, 64, 64, 64, 64, 64, 64, 64, 127);
    v[6] = mk(-64, -64, -64, -64, 64, 64, 64, 64, -128);
    v[7] = mk(-128, -128, -128, -128, -128, -128, -128, -128, 127);
    v[8] = mk(10, -5, 100, -50, 20, 7, 3, -2, 9);
    v[9] = mk(127, -128, 0, 0, 127, 127, 0, 0, -2);
    iRst = 0;
    bus.inValid = 0;
    bus.dataA = 0;
    bus.dataB = 0;
    bus.outReady = 1;
    repeat (2) @(negedge iClk);
    chk("rst_outValid", int'(bus.outValid), 0);
    chk("rst_dataOut", int'($signed(bus.dataOut)), 0);
    iRst = 1;
    @(negedge iClk);
    chk("rst_inReady", int'(bus.inReady), 1);
    for (int i = 0; i < 10; i++) begin
      group(v[i], d);
      chk($sformatf("vec%0d", i), d, int'($signed(v[i].exp)));
    end
    for (int k = 0; k < 4; k++) send(32, 32);
    chk("lat_requant_outValid", int'(bus.outValid), 0);
    chk("lat_requant_inReady", int'(bus.inReady), 0);
    @(negedge iClk);
    chk("lat_out_outValid", int'(bus.outValid), 1);
    chk("lat_out_dataOut", int'($signed(bus.dataOut)), 64);
    @(negedge iClk);
    chk("lat_after_outValid", int'(bus.outValid), 0);
    chk("lat_after_inReady", int'(bus.inReady), 1);
    bus.outReady = 0;
    for (int k = 0; k < 4; k++) send(32, 32);
    get_out(d);
    chk("bp_first", d, 64);
    bus.inValid = 1;
    bus.dataA = 8'sd127;
    bus.dataB = 8'sd127;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_outValid%0d", c), int'(bus.outValid), 1);
      chk($sformatf("bp_dataOut%0d", c), int'($signed(bus.dataOut)), 64);
      chk($sformatf("bp_inReady%0d", c), int'(bus.inReady), 0);
      @(negedge iClk);
    end
    bus.inValid = 0;
    bus.outReady = 1;
    @(negedge iClk);
    chk("bp_release_outValid", int'(bus.outValid), 0);
    group(v[1], d);
    chk("bp_fresh_acc", d, 1);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      bus.inValid = pat[i][0];
      bus.dataA = 8'sd16;
      bus.dataB = 8'sd64;
      if (pat[i] == 1 && bus.inReady) n++;
      @(negedge iClk);
    end
    bus.inValid = 0;
    chk("gap_accepts", n, 4);
    get_out(d);
    chk("gap_result", d, 64);
    send(64, 64);
    send(64, 64);
    iRst = 0;
    @(negedge iClk);
    iRst = 1;
    chk("midrst_outValid", int'(bus.outValid), 0);
    chk("midrst_dataOut", int'($signed(bus.dataOut)), 0);
    chk("midrst_inReady", int'(bus.inReady), 1);
    group(v[0], d);
    chk("midrst_fresh", d, 64);
    bus.outReady = 0;
    for (int k = 0; k < 4; k++) send(32, 32);
    get_out(d);
    iRst = 0;
    @(negedge iClk);
    iRst = 1;
    bus.outReady = 1;
    chk("outrst_outValid", int'(bus.outValid), 0);
    chk("outrst_dataOut", int'($signed(bus.dataOut)), 0);
    group(v[1], d);
    chk("outrst_fresh", d, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
